// File: rtl/shift_cmd_scheduler_if.sv
// Button inputs and shifter-side command/status outputs of the shift command scheduler.
// The scheduler connects through the slave modport; the driver of the buttons uses master.
interface shift_cmd_scheduler_if;
    logic       btn_left;
    logic       btn_right;
    logic       shift_left;
    logic       shift_right;
    logic [3:0] rate;
    logic [2:0] q_count;
    logic       busy;
    logic       overflow;

    modport master (
        output btn_left, btn_right,
        input  shift_left, shift_right, rate, q_count, busy, overflow
    );

    modport slave (
        input  btn_left, btn_right,
        output shift_left, shift_right, rate, q_count, busy, overflow
    );
endinterface

// File: rtl/shift_cmd_scheduler.sv
// Debounces the left/right buttons, queues press events in a 4-deep FIFO and issues
// spaced single-cycle shift pulses, keeping a mirror of the shifter's one-hot rate.
module shift_cmd_scheduler #(
    parameter int DB_CYCLES  = 4,
    parameter int GAP_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    shift_cmd_scheduler_if.slave bus
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Index 0 = left button, index 1 = right button.
    logic [1:0]     meta_q;
    logic [1:0]     sync_q;
    logic [1:0]     db_q;
    logic [DBW-1:0] db_cnt_q [2];
    logic [1:0]     press;

    logic [3:0] fifo_q;
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic       head;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q;
    logic [3:0]    rate_q;
    logic          shift_left_q;
    logic          shift_right_q;
    logic          overflow_q;

    logic one_press;
    logic full;
    logic push;
    logic pop;
    logic issue_next;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking assignments here would chain the synchronizer stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            meta_q <= {bus.btn_right, bus.btn_left};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= sync_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // A press is the cycle in which the debounced level is about to flip 0 -> 1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i] = sync_q[i] && !db_q[i] && (db_cnt_q[i] == DB_LAST);
        end
    end

    assign one_press  = press[0] ^ press[1];
    assign full       = (count_q == 3'd4);
    assign push       = one_press && !full;
    assign head       = fifo_q[rd_ptr_q];
    assign issue_next = (state_q == IDLE) && (count_q != 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // value held and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE:    if (count_q != 3'd0) state_d = ISSUE;
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT:    if (gap_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the FIFO storage is reset too, because a reset must discard queued
    // commands and the storage is only four flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= press[0];
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Pulses are registered on the IDLE->ISSUE edge so they coincide with ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q         <= '0;
            rate_q        <= 4'b0001;
            shift_left_q  <= 1'b0;
            shift_right_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            shift_left_q  <= issue_next && head;
            shift_right_q <= issue_next && !head;
            overflow_q    <= one_press && full;

            if (state_q == ISSUE) begin
                gap_q <= GAP_LOAD;
            end else if (state_q == WAIT && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end

            if (pop) begin
                if (head) rate_q <= rate_q[3] ? rate_q : {rate_q[2:0], 1'b0};
                else      rate_q <= rate_q[0] ? rate_q : {1'b0, rate_q[3:1]};
            end
        end
    end

    assign bus.shift_left  = shift_left_q;
    assign bus.shift_right = shift_right_q;
    assign bus.rate        = rate_q;
    assign bus.q_count     = count_q;
    assign bus.busy        = (state_q != IDLE) || (count_q != 3'd0);
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_shift_cmd_scheduler.sv
// Directed bench: instance A (DB=4, GAP=4) for debounce/latency cases, instance B
// (DB=1, GAP=4) to press fast enough to fill the queue and overflow it.
module tb_shift_cmd_scheduler;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int a_left_cnt = 0, a_right_cnt = 0, a_ovf = 0;
    int b_left_cnt = 0, b_right_cnt = 0, b_ovf = 0, b_qmax = 0;
    int both_err   = 0;
    int b_pulses[$];

    shift_cmd_scheduler_if ia ();
    shift_cmd_scheduler_if ib ();

    shift_cmd_scheduler #(.DB_CYCLES(4), .GAP_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia.slave)
    );
    shift_cmd_scheduler #(.DB_CYCLES(1), .GAP_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ia.shift_left)  a_left_cnt++;
        if (ia.shift_right) a_right_cnt++;
        if (ia.overflow)    a_ovf++;
        if (ia.shift_left && ia.shift_right) both_err++;
        if (ib.shift_left)  b_left_cnt++;
        if (ib.shift_right) b_right_cnt++;
        if (ib.overflow)    b_ovf++;
        if (ib.shift_left && ib.shift_right) both_err++;
        if (ib.shift_left || ib.shift_right) b_pulses.push_back(cyc);
        if (int'(ib.q_count) > b_qmax) b_qmax = int'(ib.q_count);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k;
    int snap_l, snap_r;
    bit glitch [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0};

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        ia.btn_left = 1'b0; ia.btn_right = 1'b0;
        ib.btn_left = 1'b0; ib.btn_right = 1'b0;
        step(3);
        check("rst_rate",     ia.rate, 4'b0001);
        check("rst_q_count",  ia.q_count, 3'd0);
        check("rst_busy",     ia.busy, 1'b0);
        check("rst_shift",    {ia.shift_left, ia.shift_right}, 2'b00);
        check("rst_overflow", ia.overflow, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(2);

        // Clean left press: 2 sync stages + 4 debounce samples before q_count=1.
        ia.btn_left = 1'b1;
        k = 0;
        do begin
            step(1);
            k++;
        end while (ia.q_count != 3'd1 && k < 20);
        check("t1_press_latency", k, 6);
        check("t1_no_pulse_yet",  ia.shift_left, 1'b0);
        step(1);
        check("t1_shift_left",  ia.shift_left, 1'b1);
        check("t1_shift_right", ia.shift_right, 1'b0);
        check("t1_q_in_issue",  ia.q_count, 3'd1);
        step(1);
        check("t1_pulse_width", ia.shift_left, 1'b0);
        check("t1_rate",        ia.rate, 4'b0010);
        check("t1_q_empty",     ia.q_count, 3'd0);
        check("t1_busy_wait",   ia.busy, 1'b1);
        step(2);
        ia.btn_left = 1'b0;
        step(1);
        check("t1_busy_last_wait", ia.busy, 1'b1);
        step(1);
        check("t1_busy_fall", ia.busy, 1'b0);
        step(20);
        check("t1_left_count",  a_left_cnt, 1);
        check("t1_right_count", a_right_cnt, 0);

        // Right-button glitches, high runs of at most 2 cycles.
        for (int i = 0; i < 12; i++) begin
            ia.btn_right = glitch[i];
            step(1);
        end
        ia.btn_right = 1'b0;
        step(20);
        check("glitch_q_count", ia.q_count, 3'd0);
        check("glitch_right",   a_right_cnt, 0);
        check("glitch_busy",    ia.busy, 1'b0);

        // Instance B: 9 left presses every 2 cycles; presses 7 and 8 hit a full queue.
        b_pulses.delete();
        b_qmax = 0;
        for (int i = 0; i < 9; i++) begin
            ib.btn_left = 1'b1;
            step(1);
            ib.btn_left = 1'b0;
            step(1);
        end
        step(70);
        check("ovf_left_pulses", b_left_cnt, 7);
        check("ovf_right",       b_right_cnt, 0);
        check("ovf_count",       b_ovf, 2);
        check("ovf_qmax",        b_qmax, 4);
        check("ovf_rate_sat",    ib.rate, 4'b1000);
        check("ovf_q_empty",     ib.q_count, 3'd0);
        check("ovf_busy",        ib.busy, 1'b0);
        for (int i = 1; i < b_pulses.size(); i++) begin
            check("ovf_spacing", b_pulses[i] - b_pulses[i-1], 6);
        end

        // Simultaneous left+right on A: both discarded.
        snap_l = a_left_cnt;
        snap_r = a_right_cnt;
        ia.btn_left  = 1'b1;
        ia.btn_right = 1'b1;
        step(8);
        ia.btn_left  = 1'b0;
        ia.btn_right = 1'b0;
        step(20);
        check("simul_left",  a_left_cnt - snap_l, 0);
        check("simul_right", a_right_cnt - snap_r, 0);
        check("simul_ovf",   a_ovf, 0);
        check("simul_rate",  ia.rate, 4'b0010);
        check("simul_q",     ia.q_count, 3'd0);

        // Instance B: queue 3 commands, reset during WAIT after the first issue.
        rst_b = 1'b0;
        step(2);
        rst_b = 1'b1;
        step(2);
        snap_l = b_left_cnt;
        for (int i = 0; i < 3; i++) begin
            ib.btn_left = 1'b1;
            step(1);
            ib.btn_left = 1'b0;
            step(1);
        end
        step(1);
        check("rstq_q_before",    ib.q_count, 3'd2);
        check("rstq_rate_before", ib.rate, 4'b0010);
        check("rstq_busy_before", ib.busy, 1'b1);
        #1 rst_b = 1'b0;
        #1;
        check("rstq_q_async",    ib.q_count, 3'd0);
        check("rstq_rate_async", ib.rate, 4'b0001);
        check("rstq_busy_async", ib.busy, 1'b0);
        check("rstq_shift",      {ib.shift_left, ib.shift_right}, 2'b00);
        step(2);
        rst_b = 1'b1;
        step(30);
        check("rstq_pulses", b_left_cnt - snap_l, 1);
        check("rstq_rate",   ib.rate, 4'b0001);

        // Button held through reset release: exactly one press.
        rst_b = 1'b0;
        ib.btn_left = 1'b1;
        step(2);
        rst_b = 1'b1;
        step(30);
        check("held_pulses", b_left_cnt - snap_l, 2);
        check("held_rate",   ib.rate, 4'b0010);
        ib.btn_left = 1'b0;
        step(10);

        // Five right presses on A from the reset rate.
        rst_a = 1'b0;
        step(2);
        rst_a = 1'b1;
        step(2);
        check("right_rst_rate", ia.rate, 4'b0001);
        snap_r = a_right_cnt;
        for (int i = 0; i < 5; i++) begin
            ia.btn_right = 1'b1;
            step(6);
            ia.btn_right = 1'b0;
            step(6);
            check("right_rate_sat", ia.rate, 4'b0001);
        end
        step(20);
        check("right_pulses", a_right_cnt - snap_r, 5);
        check("right_q",      ia.q_count, 3'd0);
        check("right_busy",   ia.busy, 1'b0);
        check("never_both",   both_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
